// File: rtl/input_loader.sv
// input_loader: frame-buffering byte loader feeding the memoryA write path (optional LOADER_PARITY_EN adds even-parity checking)
module input_loader #(
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
`ifdef LOADER_PARITY_EN
  input  logic       in_parity,
  output logic       parity_err,
`endif
  output logic       in_ready,
  input  logic       weA,
  output logic [7:0] dataOutA,
  output logic       frame_ready,
  output logic       frame_done,
  output logic       underrun
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, accept_cnt, pop_cnt, count_n, accept_n, pop_n;
  logic accept, bad, store, pop, last_pop, in_ready_n;
  assign accept = in_valid & in_ready;
`ifdef LOADER_PARITY_EN
  assign bad = ^{in_data, in_parity};
`else
  assign bad = 1'b0;
`endif
  assign store = accept & ~bad;
  assign pop = weA & (state == DRAIN) & (count != '0);
  assign last_pop = pop & (pop_cnt == CW'(FRAME_LEN - 1));
  assign frame_ready = (state == DRAIN);
  assign dataOutA = (count == '0) ? 8'h00 : mem[rd_ptr];
  // next-state, occupancy and frame counters; in_ready is precomputed from next values so it registers cleanly
  always_comb begin
    state_n = state;
    count_n = count;
    accept_n = accept_cnt;
    pop_n = pop_cnt;
    if (store) begin
      count_n = count + 1'b1;
      accept_n = accept_cnt + 1'b1;
    end
    if (pop) begin
      count_n = count - 1'b1;
      pop_n = pop_cnt + 1'b1;
    end
    case (state)
      IDLE:  state_n = store ? FILL : IDLE;
      FILL:  state_n = (accept_cnt == CW'(FRAME_LEN)) ? DRAIN : FILL;
      DRAIN: if (last_pop) begin
        state_n = IDLE;
        accept_n = '0;
        pop_n = '0;
      end
      default: state_n = IDLE;
    endcase
    in_ready_n = (state_n != DRAIN) && (count_n != CW'(DEPTH)) && (accept_n < CW'(FRAME_LEN));
  end
  // control state, pointers and sticky flags
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      accept_cnt <= '0;
      pop_cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_ready <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
`ifdef LOADER_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      state <= state_n;
      count <= count_n;
      accept_cnt <= accept_n;
      pop_cnt <= pop_n;
      wr_ptr <= wr_ptr + AW'(store);
      rd_ptr <= rd_ptr + AW'(pop);
      in_ready <= in_ready_n;
      frame_done <= last_pop;
      underrun <= underrun | (weA & ~pop);
`ifdef LOADER_PARITY_EN
      parity_err <= parity_err | (accept & bad);
`endif
    end
  end
  // FIFO storage; contents need no reset since emptiness gates the output
  always_ff @(posedge clock) begin
    if (store) mem[wr_ptr] <= in_data;
  end
endmodule

// File: tb/tb_input_loader.sv
// tb_input_loader: scoreboard bench for input_loader (define LOADER_PARITY_EN to also exercise parity)
module tb_input_loader;
  logic clock = 1'b0, reset = 1'b1, in_valid = 1'b0, weA = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, frame_ready, frame_done, underrun;
  logic [7:0] dataOutA;
`ifdef LOADER_PARITY_EN
  logic in_parity = 1'b0, parity_err;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];

  always #5 clock = ~clock;

  input_loader dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
`ifdef LOADER_PARITY_EN
    .in_parity(in_parity), .parity_err(parity_err),
`endif
    .in_ready(in_ready), .weA(weA), .dataOutA(dataOutA),
    .frame_ready(frame_ready), .frame_done(frame_done), .underrun(underrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic corrupt);
    int n = 0;
    in_data = b;
`ifdef LOADER_PARITY_EN
    in_parity = (^b) ^ corrupt;
`endif
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    @(posedge clock);
    #1 in_valid = 1'b0;
    if (!corrupt) exp_q.push_back(b);
  endtask

  task automatic pop(input int gap);
    weA = 1'b1;
    cyc(1);
    weA = 1'b0;
    cyc(gap);
  endtask

  // scoreboard monitor: every accepted pop must present the next expected byte
  always @(negedge clock) begin
    if (!reset && weA && frame_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pop", 0, 1);
      else chk("dataOutA", dataOutA, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(2);
    reset = 1'b0;
    chk("rst_in_ready", in_ready, 0);
    cyc(1);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_data", dataOutA, 8'h00);
    chk("idle_frame_ready", frame_ready, 0);
    chk("idle_frame_done", frame_done, 0);
    chk("idle_underrun", underrun, 0);
    for (int i = 0; i < 8; i++) send(8'h10 + 8'(i), 1'b0);
    @(negedge clock);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_frame_ready", frame_ready, 0);
    @(negedge clock);
    chk("drain_frame_ready", frame_ready, 1);
    chk("drain_head", dataOutA, 8'h10);
    chk("drain_in_ready", in_ready, 0);
    cyc(1);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) chk("no_early_done", frame_done, 0);
      pop(i == 7 ? 0 : i % 3);
    end
    chk("done_pulse", frame_done, 1);
    chk("done_frame_ready", frame_ready, 0);
    chk("done_in_ready", in_ready, 1);
    chk("done_underrun", underrun, 0);
    chk("done_data", dataOutA, 8'h00);
    cyc(1);
    chk("done_one_cycle", frame_done, 0);
    pop(0);
    chk("underrun_set", underrun, 1);
    chk("underrun_data", dataOutA, 8'h00);
    chk("underrun_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) send(8'h30 + 8'(i), 1'b0);
    cyc(2);
    chk("f2_frame_ready", frame_ready, 1);
    chk("f2_head", dataOutA, 8'h30);
    chk("underrun_sticky", underrun, 1);
    for (int i = 0; i < 5; i++) pop(0);
    reset = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_frame_ready", frame_ready, 0);
    chk("arst_data", dataOutA, 8'h00);
    chk("arst_underrun", underrun, 0);
    chk("arst_frame_done", frame_done, 0);
    exp_q.delete();
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rel_in_ready", in_ready, 1);
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1'b0);
    cyc(2);
    chk("f3_frame_ready", frame_ready, 1);
    chk("f3_head", dataOutA, 8'h20);
    for (int i = 0; i < 8; i++) pop(1);
    chk("f3_drained", exp_q.size(), 0);
    chk("f3_underrun", underrun, 0);
`ifdef LOADER_PARITY_EN
    chk("par_clear", parity_err, 0);
    send(8'h03, 1'b1);
    chk("par_err_set", parity_err, 1);
    chk("par_in_ready", in_ready, 1);
    send(8'h03, 1'b0);
    for (int i = 1; i < 7; i++) send(8'h40 + 8'(i), 1'b0);
    cyc(2);
    chk("par_not_counted", frame_ready, 0);
    send(8'h47, 1'b0);
    cyc(2);
    chk("par_frame_ready", frame_ready, 1);
    chk("par_head", dataOutA, 8'h03);
    for (int i = 0; i < 8; i++) pop(0);
    chk("par_drained", exp_q.size(), 0);
    chk("par_sticky", parity_err, 1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
